seg7_capture: RTL and testbench
===============================

SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 SHALL provide parameter STABLE_CYCLES, default 4, meaning consecutive clocks a select+pattern must hold before capture (legal 1..255).
REQ-002 SHALL provide parameter PMASK, default 6'b011111, meaning digit positions required to complete a frame.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, reset (synchronous, active-low).
REQ-005 SHALL have port seg_n, input, 8, active-low segments; bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp.
REQ-006 SHALL have port dig_n, input, 6, active-low digit selects; bit i = position i.
REQ-007 SHALL have port digits, output, 24, captured frame; bits [4i+3:4i] = code of position i.
REQ-008 SHALL have port frame_valid, output, 1, one-clock pulse when digits updates.
REQ-009 SHALL have port frame_cnt, output, 8, count of completed frames.
REQ-010 SHALL have port err, output, 1, sticky flag: an unrecognised pattern was captured.
REQ-011 SHALL have port dp_flags, output, 6, captured decimal points per position.

Function
REQ-012 SHALL treat a select as valid only when exactly one bit of ~dig_n is 1; zero or multiple active bits SHALL be invalid.
REQ-013 SHALL implement FSM states IDLE, SETTLE, HOLD.
REQ-014 IDLE: on valid select, load stability counter with 1, latch select and seg_n, go SETTLE; else stay IDLE.
REQ-015 SETTLE: if select invalid -> IDLE; if select or seg_n differs from latch -> relatch, counter=1, stay SETTLE; if unchanged, increment; at counter==STABLE_CYCLES perform capture and go HOLD.
REQ-016 HOLD: no further capture until select or seg_n changes; change to valid select -> SETTLE (counter=1, relatch); invalid -> IDLE.
REQ-017 Capture latency SHALL be exactly STABLE_CYCLES clocks after the first cycle of a stable pattern (STABLE_CYCLES=1: capture on the clock edge after first sample).
REQ-018 Decode of ~seg_n[7:1] (abcdefg): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110010, 8=1111111, 9=1110011 -> codes 0..9; 0000001 (dash) -> 4'hF; 0000000 (blank) -> 4'hA; anything else -> 4'hE and set err.
REQ-019 Capture SHALL write code into shadow register for position p and set mask bit p; recapture of p before frame completion overwrites shadow, mask unchanged.
REQ-020 When (mask | bit p) covers PMASK at capture, on that same edge: digits <= shadow including new code, frame_valid=1 next cycle only, frame_cnt+1, mask cleared.
REQ-021 frame_cnt SHALL wrap 255 -> 0 without flag.
REQ-022 Positions outside PMASK SHALL still be captured into shadow but never complete a frame alone.
REQ-023 digits SHALL hold its value between frames.

Reset
REQ-024 On rst==0 at a clock edge: state=IDLE, counter=0, mask=0, shadow=0, digits=24'h0, frame_valid=0, frame_cnt=0, err=0, dp_flags=0.
REQ-025 Reset mid-SETTLE or mid-frame SHALL discard partial capture; first frame after reset requires all PMASK positions again.
REQ-026 err SHALL clear only by reset.

Configuration
REQ-027 With macro SEG7_CAPTURE_DP_EN defined, ~seg_n[0] SHALL be captured with the digit and copied to dp_flags[p] on frame completion, and dp SHALL participate in pattern-change detection.
REQ-028 Without SEG7_CAPTURE_DP_EN, seg_n[0] SHALL be ignored entirely and dp_flags SHALL be constant 0.

Verification
REQ-029 Scan positions 0..4 with codes 5,9,F,3,0 (seg_n 01001001, 00011001, 11111101, 00001101, 00000011), each held 6 clocks -> one frame_valid, digits[19:0]=20'h03F95, frame_cnt=1.
REQ-030 Hold position 2 pattern 3 clocks then change to position 3 (STABLE_CYCLES=4) -> no capture of position 2, mask bit 2 stays 0.
REQ-031 dig_n=6'b111100 (two active) for 10 clocks -> state IDLE, no capture, no frame_valid.
REQ-032 Capture seg_n=01010101 on position 1 -> code 4'hE in digits[7:4] at frame end, err=1 until rst pulsed.
REQ-033 Complete 256 frames -> frame_cnt returns 0; assert rst after 3 of 5 positions captured -> next frame_valid only after all 5 recaptured.
REQ-034 With SEG7_CAPTURE_DP_EN, position 0 seg_n=01001000 -> digits[3:0]=5, dp_flags[0]=1; without macro, dp_flags=0.

Source files
------------

// File: rtl/seg7_capture.sv
// seg7_capture: debounces a multiplexed 7-segment scan (one-hot digit select plus segments) and assembles
// decoded digit codes into frames. Define SEG7_CAPTURE_DP_EN to also capture decimal points into dp_flags.
module seg7_capture #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter logic [5:0]  PMASK         = 6'b011111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_n,
  input  logic [5:0]  dig_n,
  output logic [23:0] digits,
  output logic        frame_valid,
  output logic [7:0]  frame_cnt,
  output logic        err,
  output logic [5:0]  dp_flags
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

  function automatic logic onehot_f(input logic [5:0] v);
    onehot_f = (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
  endfunction

  function automatic logic [2:0] pos_f(input logic [5:0] v);
    pos_f = 3'd0;
    for (int i = 0; i < 6; i++) begin
      pos_f = v[i] ? 3'(i) : pos_f;
    end
  endfunction

  // Segment order is abcdefg, a in the MSB, active high.
  function automatic logic [3:0] decode_f(input logic [6:0] abcdefg);
    case (abcdefg)
      7'b1111110: decode_f = 4'h0;
      7'b0110000: decode_f = 4'h1;
      7'b1101101: decode_f = 4'h2;
      7'b1111001: decode_f = 4'h3;
      7'b0110011: decode_f = 4'h4;
      7'b1011011: decode_f = 4'h5;
      7'b1011111: decode_f = 4'h6;
      7'b1110010: decode_f = 4'h7;
      7'b1111111: decode_f = 4'h8;
      7'b1110011: decode_f = 4'h9;
      7'b0000001: decode_f = 4'hF;
      7'b0000000: decode_f = 4'hA;
      default:    decode_f = 4'hE;
    endcase
  endfunction

  state_t      state_r, state_nxt_s;
  logic [7:0]  cnt_r, cnt_nxt_s;
  logic [5:0]  sel_s, sel_lat_r;
  logic [6:0]  pat_s, pat_lat_r;
  logic        sel_valid_s, changed_s, dp_chg_s;
  logic        load_s, capture_s, complete_s;
  logic [3:0]  code_s;
  logic [2:0]  pos_s;
  logic [23:0] shadow_r, shadow_upd_s;
  logic [5:0]  mask_r, mask_upd_s;

  assign sel_s       = ~dig_n;
  assign pat_s       = ~seg_n[7:1];
  assign sel_valid_s = onehot_f(sel_s);
  assign changed_s   = (sel_s != sel_lat_r) || (pat_s != pat_lat_r) || dp_chg_s;

  // Next-state logic: the counter holds the number of consecutive samples matching the latch.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    load_s      = 1'b0;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (sel_valid_s) begin
          state_nxt_s = SETTLE;
          cnt_nxt_s   = 8'd1;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETTLE: begin
        if (!sel_valid_s) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 8'd0;
        end else if (changed_s) begin
          cnt_nxt_s   = 8'd1;
          load_s      = 1'b1;
        end else if (cnt_r >= STABLE_LIM) begin
          state_nxt_s = HOLD;
          capture_s   = 1'b1;
        end else begin
          cnt_nxt_s   = cnt_r + 8'd1;
        end
      end
      HOLD: begin
        if (!sel_valid_s) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 8'd0;
        end else if (changed_s) begin
          state_nxt_s = SETTLE;
          cnt_nxt_s   = 8'd1;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 8'd0;
      end
    endcase
  end

  // State, stability counter and input latch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= IDLE;
      cnt_r     <= 8'd0;
      sel_lat_r <= 6'd0;
      pat_lat_r <= 7'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (load_s) begin
        sel_lat_r <= sel_s;
        pat_lat_r <= pat_s;
      end
    end
  end

  // Shadow image with the captured nibble merged in; the latch is stable at capture time.
  always_comb begin
    code_s       = decode_f(pat_lat_r);
    pos_s        = pos_f(sel_lat_r);
    shadow_upd_s = shadow_r;
    shadow_upd_s[4*pos_s +: 4] = code_s;
    mask_upd_s   = mask_r | sel_lat_r;
    complete_s   = capture_s && ((mask_upd_s & PMASK) == PMASK);
  end

  // Shadow, frame assembly and status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow_r    <= 24'h0;
      mask_r      <= 6'd0;
      digits      <= 24'h0;
      frame_valid <= 1'b0;
      frame_cnt   <= 8'd0;
      err         <= 1'b0;
    end else begin
      frame_valid <= complete_s;
      if (capture_s) begin
        shadow_r <= shadow_upd_s;
        err      <= err | (code_s == 4'hE);
        if (complete_s) begin
          digits    <= shadow_upd_s;
          frame_cnt <= frame_cnt + 8'd1;
          mask_r    <= 6'd0;
        end else begin
          mask_r    <= mask_upd_s;
        end
      end
    end
  end

`ifdef SEG7_CAPTURE_DP_EN
  logic       dp_s, dp_lat_r;
  logic [5:0] dp_shadow_r, dp_upd_s, dp_flags_r;

  assign dp_s     = ~seg_n[0];
  assign dp_chg_s = (dp_s != dp_lat_r);
  assign dp_upd_s = (dp_shadow_r & ~sel_lat_r) | (sel_lat_r & {6{dp_lat_r}});
  assign dp_flags = dp_flags_r;

  // Decimal point latch, shadow and frame copy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dp_lat_r    <= 1'b0;
      dp_shadow_r <= 6'd0;
      dp_flags_r  <= 6'd0;
    end else begin
      if (load_s) begin
        dp_lat_r <= dp_s;
      end
      if (capture_s) begin
        dp_shadow_r <= dp_upd_s;
      end
      if (complete_s) begin
        dp_flags_r <= dp_upd_s;
      end
    end
  end
`else
  logic unused_dp_s;

  assign unused_dp_s = seg_n[0];
  assign dp_chg_s    = 1'b0;
  assign dp_flags    = 6'd0;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed scan sequences checked every cycle against a run-length behavioural model,
// plus literal expectations for the key frames.
module tb_seg7_capture;
  localparam int STABLE = 4;
  localparam logic [5:0] PM = 6'b011111;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg_n;
  logic [5:0]  dig_n;
  logic [23:0] digits;
  logic        frame_valid;
  logic [7:0]  frame_cnt;
  logic        err;
  logic [5:0]  dp_flags;

  int errors = 0;
  int checks = 0;
  int fv_seen = 0;
  bit chk_en = 1'b0;

  seg7_capture #(.STABLE_CYCLES(STABLE), .PMASK(PM)) dut (
    .clk(clk), .rst(rst), .seg_n(seg_n), .dig_n(dig_n), .digits(digits),
    .frame_valid(frame_valid), .frame_cnt(frame_cnt), .err(err), .dp_flags(dp_flags)
  );

  always #5 clk = ~clk;

  // abcdefg per digit, a first
  logic [6:0] segs [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                            7'b1011011, 7'b1011111, 7'b1110010, 7'b1111111, 7'b1110011};

  localparam logic [7:0] P5 = 8'b01001001, P9 = 8'b00011001, PF = 8'b11111101, P3 = 8'b00001101;
  localparam logic [7:0] P0 = 8'b00000011, PBAD = 8'b01010101, P5DP = 8'b01001000, PBLANK = 8'b11111111;
  localparam logic [7:0] P1 = 8'b10011111;

  // model state
  int         run = 0;
  logic [5:0] prev_sel = 6'd0;
  logic [7:0] prev_pat = 8'd0;
  logic [3:0] m_sh [6] = '{default: 4'h0};
  logic [5:0] m_shdp = 6'd0, m_mask = 6'd0, m_dp = 6'd0;
  logic [23:0] m_digits = 24'h0;
  logic        m_fv = 1'b0, m_err = 1'b0;
  int          m_cnt = 0;

  function automatic logic [3:0] m_decode(input logic [6:0] s);
    m_decode = 4'hE;
    for (int d = 0; d < 10; d++) if (segs[d] == s) m_decode = 4'(d);
    if (s == 7'b0000001) m_decode = 4'hF;
    if (s == 7'b0000000) m_decode = 4'hA;
  endfunction

  task automatic model_step();
    logic [5:0] sel;
    logic [7:0] pat;
    int p;
    logic [3:0] c;
    sel = ~dig_n;
    pat = seg_n;
`ifndef SEG7_CAPTURE_DP_EN
    pat[0] = 1'b1;
`endif
    m_fv = 1'b0;
    if (!rst) begin
      run = 0; m_mask = 6'd0; m_shdp = 6'd0; m_dp = 6'd0; m_digits = 24'h0;
      m_err = 1'b0; m_cnt = 0;
      for (int i = 0; i < 6; i++) m_sh[i] = 4'h0;
    end else begin
      if ($countones(sel) != 1) run = 0;
      else if (run > 0 && sel == prev_sel && pat == prev_pat) run++;
      else run = 1;
      if (run == STABLE + 1) begin
        p = 0;
        for (int i = 0; i < 6; i++) if (sel[i]) p = i;
        c = m_decode(~pat[7:1]);
        m_sh[p] = c;
        m_mask[p] = 1'b1;
`ifdef SEG7_CAPTURE_DP_EN
        m_shdp[p] = ~pat[0];
`endif
        if (c == 4'hE) m_err = 1'b1;
        if ((m_mask & PM) == PM) begin
          for (int i = 0; i < 6; i++) m_digits[4*i +: 4] = m_sh[i];
          m_fv = 1'b1;
          m_cnt = (m_cnt + 1) % 256;
          m_mask = 6'd0;
          m_dp = m_shdp;
        end
      end
    end
    prev_sel = sel;
    prev_pat = pat;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("digits", 32'(digits), 32'(m_digits));
      check("frame_valid", 32'(frame_valid), 32'(m_fv));
      check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
      check("err", 32'(err), 32'(m_err));
      check("dp_flags", 32'(dp_flags), 32'(m_dp));
      if (frame_valid === 1'b1) fv_seen++;
    end
  end

  task automatic show(input int pos, input logic [7:0] pat, input int n);
    dig_n = (pos < 0) ? 6'b111111 : ~(6'd1 << pos);
    seg_n = pat;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] pat_of(input int d);
    pat_of = {~segs[d], 1'b1};
  endfunction

  initial begin
    rst = 1'b0; dig_n = 6'b111111; seg_n = 8'hFF;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_digits", 32'(digits), 32'h0);
    check("reset_cnt", 32'(frame_cnt), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    rst = 1'b1;

    // basic scan 5,9,F,3,0
    show(0, P5, 6); show(1, P9, 6); show(2, PF, 6); show(3, P3, 6); show(4, P0, 6); show(-1, PBLANK, 2);
    check("scan_digits", 32'(digits), 32'h003F95);
    check("scan_cnt", 32'(frame_cnt), 32'd1);
    check("scan_fv", 32'(fv_seen), 32'd1);

    // position 2 unstable, not captured until revisited
    show(2, P5, 3); show(3, P9, 6); show(0, P0, 6); show(1, P3, 6); show(4, PF, 6); show(-1, PBLANK, 2);
    check("short_hold_cnt", 32'(frame_cnt), 32'd1);
    show(2, P5, 6); show(-1, PBLANK, 2);
    check("late_pos2_digits", 32'(digits), 32'h0F9530);
    check("late_pos2_cnt", 32'(frame_cnt), 32'd2);

    // two selects active
    show(-1, P5, 0); dig_n = 6'b111100; repeat (10) @(negedge clk);
    check("multi_sel_fv", 32'(fv_seen), 32'd2);

    // exact-threshold capture, one-short miss, bad pattern
    show(0, PBLANK, 5); show(1, P3, 4); show(-1, PBLANK, 1);
    show(1, PBAD, 6); show(2, P5, 5); show(3, P9, 5); show(4, P0, 5); show(-1, PBLANK, 2);
    check("bad_digits", 32'(digits), 32'h0095EA);
    check("bad_err", 32'(err), 32'd1);

    // recapture overwrite and out-of-mask position
    show(0, P9, 6); show(-1, PBLANK, 1); show(0, P3, 6); show(5, P5, 6);
    show(1, P0, 5); show(2, P0, 5); show(3, P0, 5); show(4, P0, 5); show(-1, PBLANK, 2);
    check("recap_digits", 32'(digits), 32'h500003);
    check("err_sticky", 32'(err), 32'd1);
    check("recap_cnt", 32'(frame_cnt), 32'd4);

    // partial frame then reset
    show(0, P5, 6); show(0, P9, 6); show(1, P3, 5); show(2, P3, 5);
    rst = 1'b0; show(-1, PBLANK, 2); rst = 1'b1;
    show(3, P5, 5); show(4, P5, 5); show(0, P1, 5); show(1, P1, 5); show(-1, PBLANK, 2);
    check("post_rst_nofv", 32'(fv_seen), 32'd4);
    check("post_rst_err", 32'(err), 32'd0);
    show(2, P1, 5); show(-1, PBLANK, 2);
    check("post_rst_fv", 32'(fv_seen), 32'd5);
    check("post_rst_digits", 32'(digits), 32'h055111);
    check("post_rst_cnt", 32'(frame_cnt), 32'd1);

    // 255 more frames wrap the counter
    for (int k = 0; k < 255; k++)
      for (int i = 0; i < 5; i++) show(i, pat_of((k + i) % 10), 5);
    show(-1, PBLANK, 2);
    check("wrap_cnt", 32'(frame_cnt), 32'd0);

    // decimal point
    show(0, P5, 3); show(0, P5DP, 3); show(-1, PBLANK, 1);
    show(0, P5DP, 5); show(1, P0, 5); show(2, P0, 5); show(3, P0, 5); show(4, P0, 5); show(-1, PBLANK, 2);
    check("dp_digit0", 32'(digits[3:0]), 32'h5);
`ifdef SEG7_CAPTURE_DP_EN
    check("dp_flags", 32'(dp_flags), 32'h01);
`else
    check("dp_flags", 32'(dp_flags), 32'h00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
